// File: rtl/ps2_note_map.sv
// PS/2 set-2 scan-code to musical-note mapper.
// Decodes make/break/extended prefixes and turns the seven home-row note keys
// into a tone half-period (cnt_freq) for a downstream beeper, plus a one-cycle
// key_flag pulse and the note index.
// Optional build macro: TYPEMATIC_FILTER_EN -- suppresses key_flag on typematic
// repeats of the key currently held down.
module ps2_note_map #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_valid,
  output logic [31:0] cnt_freq,
  output logic        key_flag,
  output logic [2:0]  note_idx
);

  // Half-period counts, truncated at elaboration.
  localparam logic [31:0] FreqC4 = 32'(CLK_FREQ / (2 * 262));
  localparam logic [31:0] FreqD4 = 32'(CLK_FREQ / (2 * 294));
  localparam logic [31:0] FreqE4 = 32'(CLK_FREQ / (2 * 330));
  localparam logic [31:0] FreqF4 = 32'(CLK_FREQ / (2 * 349));
  localparam logic [31:0] FreqG4 = 32'(CLK_FREQ / (2 * 392));
  localparam logic [31:0] FreqA4 = 32'(CLK_FREQ / (2 * 440));
  localparam logic [31:0] FreqB4 = 32'(CLK_FREQ / (2 * 494));

  localparam logic [7:0] CodeBreak = 8'hF0;
  localparam logic [7:0] CodeExt   = 8'hE0;

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  state_e      state_q;
  logic [7:0]  held_code;   // 0x00 means no note key held

  logic        map_hit;
  logic [2:0]  map_idx;
  logic [31:0] map_freq;
  logic        repeat_blk;

  // Lookup of the current byte as a note make code.
  always_comb begin
    map_hit  = 1'b0;
    map_idx  = 3'd0;
    map_freq = FreqC4;
    case (ps2_data)
      8'h1C: begin map_hit = 1'b1; map_idx = 3'd0; map_freq = FreqC4; end
      8'h1B: begin map_hit = 1'b1; map_idx = 3'd1; map_freq = FreqD4; end
      8'h23: begin map_hit = 1'b1; map_idx = 3'd2; map_freq = FreqE4; end
      8'h2B: begin map_hit = 1'b1; map_idx = 3'd3; map_freq = FreqF4; end
      8'h34: begin map_hit = 1'b1; map_idx = 3'd4; map_freq = FreqG4; end
      8'h33: begin map_hit = 1'b1; map_idx = 3'd5; map_freq = FreqA4; end
      8'h3B: begin map_hit = 1'b1; map_idx = 3'd6; map_freq = FreqB4; end
      default: ;
    endcase
  end

`ifdef TYPEMATIC_FILTER_EN
  // A repeat of the held key is swallowed.
  assign repeat_blk = (held_code != 8'h00) && (held_code == ps2_data);
`else
  assign repeat_blk = 1'b0;
`endif

  // Decode FSM with registered note outputs and held-key tracking.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      key_flag  <= 1'b0;
      note_idx  <= 3'd0;
      cnt_freq  <= FreqC4;
      held_code <= 8'h00;
    end else begin
      key_flag <= 1'b0;
      if (ps2_valid) begin
        unique case (state_q)
          StIdle: begin
            if (ps2_data == CodeBreak) begin
              state_q <= StBrk;
            end else if (ps2_data == CodeExt) begin
              state_q <= StExt;
            end else if (map_hit) begin
              held_code <= ps2_data;
              if (!repeat_blk) begin
                key_flag <= 1'b1;
                note_idx <= map_idx;
                cnt_freq <= map_freq;
              end
            end
          end
          StBrk: begin
            // Any byte here is the released key, prefixes included.
            state_q <= StIdle;
            if (ps2_data == held_code) begin
              held_code <= 8'h00;
            end
          end
          StExt: begin
            state_q <= (ps2_data == CodeBreak) ? StExtBrk : StIdle;
          end
          StExtBrk: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_note_map.sv
// Self-checking bench for ps2_note_map: expected note pulses are queued as
// bytes are driven and popped whenever key_flag is seen high.
module tb_ps2_note_map;

  logic        sys_clk;
  logic        sys_rst;
  logic [7:0]  ps2_data;
  logic        ps2_valid;
  logic [31:0] cnt_freq;
  logic        key_flag;
  logic [2:0]  note_idx;

  int total;
  int bad;

  typedef struct packed {
    logic [31:0] freq;
    logic [2:0]  idx;
  } note_t;

  note_t exp_q[$];

  localparam logic [31:0] ExpFreq [7] = '{95419, 85034, 75757, 71633, 63775, 56818, 50607};

  ps2_note_map #(
    .CLK_FREQ(50_000_000)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .ps2_data (ps2_data),
    .ps2_valid(ps2_valid),
    .cnt_freq (cnt_freq),
    .key_flag (key_flag),
    .note_idx (note_idx)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Pulse monitor: every key_flag cycle must match the oldest queued note.
  always @(negedge sys_clk) begin
    if (key_flag === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_key_flag", 32'(key_flag), 32'd0);
      end else begin
        note_t e;
        e = exp_q.pop_front();
        check_eq("pulse_cnt_freq", cnt_freq, e.freq);
        check_eq("pulse_note_idx", 32'(note_idx), 32'(e.idx));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge sys_clk);
    ps2_data  = b;
    ps2_valid = 1'b1;
    @(negedge sys_clk);
    ps2_valid = 1'b0;
  endtask

  task automatic send_note(input logic [7:0] b, input int idx);
    note_t e;
    e.freq = ExpFreq[idx];
    e.idx  = 3'(idx);
    exp_q.push_back(e);
    send(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    sys_rst   = 1'b1;
    ps2_valid = 1'b0;
    ps2_data  = 8'h00;
    idle(3);
    sys_rst = 1'b0;
    idle(1);

    // Reset state
    check_eq("rst_key_flag", 32'(key_flag), 32'd0);
    check_eq("rst_cnt_freq", cnt_freq, 32'd95419);
    check_eq("rst_note_idx", 32'(note_idx), 32'd0);

    // Basic make code
    send_note(8'h1C, 0);
    idle(2);
    check_eq("c4_cnt_freq", cnt_freq, 32'd95419);

    // Make then break of the same key
    send_note(8'h33, 5);
    send(8'hF0);
    send(8'h33);
    idle(2);
    check_eq("a4_break_cnt", cnt_freq, 32'd56818);
    check_eq("a4_held_clear", 32'(dut.held_code), 32'd0);

    // Extended make and extended break produce nothing
    send(8'hE0);
    send(8'h1C);
    send(8'hE0);
    send(8'hF0);
    send(8'h1C);
    idle(2);
    check_eq("ext_cnt_freq", cnt_freq, 32'd56818);
    check_eq("ext_note_idx", 32'(note_idx), 32'd5);

    // Typematic repeats
`ifdef TYPEMATIC_FILTER_EN
    send_note(8'h2B, 3);
    send(8'h2B);
    send(8'h2B);
`else
    send_note(8'h2B, 3);
    send_note(8'h2B, 3);
    send_note(8'h2B, 3);
`endif
    idle(2);
    check_eq("typ_cnt_freq", cnt_freq, 32'd71633);
    check_eq("typ_note_idx", 32'(note_idx), 32'd3);

    // Reset wins over a simultaneous strobe and drops the pending F0
    send(8'hF0);
    @(negedge sys_clk);
    sys_rst   = 1'b1;
    ps2_data  = 8'h1B;
    ps2_valid = 1'b1;
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    ps2_valid = 1'b0;
    check_eq("rstv_key_flag", 32'(key_flag), 32'd0);
    check_eq("rstv_cnt_freq", cnt_freq, 32'd95419);
    check_eq("rstv_note_idx", 32'(note_idx), 32'd0);
    check_eq("rstv_held", 32'(dut.held_code), 32'd0);
    send_note(8'h1B, 1);
    idle(2);
    check_eq("d4_cnt_freq", cnt_freq, 32'd85034);

    // Unmapped make code is a no-op
    send_note(8'h3B, 6);
    send(8'h15);
    idle(2);
    check_eq("unmap_cnt_freq", cnt_freq, 32'd50607);
    check_eq("unmap_note_idx", 32'(note_idx), 32'd6);

    // F0 F0: second F0 is the break target, then a fresh make decodes
    send(8'hF0);
    send(8'hF0);
    send_note(8'h1C, 0);
    // E0 E0: returns to idle, next byte is a plain make
    send(8'hE0);
    send(8'hE0);
    send_note(8'h34, 4);
    send_note(8'h23, 2);
    idle(3);
    check_eq("tail_cnt_freq", cnt_freq, 32'd75757);
    check_eq("tail_note_idx", 32'(note_idx), 32'd2);

    check_eq("pending_pulses", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
